// File: rtl/xmit_pkg.sv
// Types and constants shared by the PHY transmit serializer and receive deframer.
// Control-word width, error-bit layout, FSM states and nibble order live here.
package xmit_pkg;

    localparam int CTRL_W = 24;
    localparam int ERR_W  = 3;

    localparam int ERR_ODD  = 0;
    localparam int ERR_RUNT = 1;
    localparam int ERR_LONG = 2;

    // Low nibble travels first on the 4-bit PHY interface.
    localparam bit NIBBLE_LO_FIRST = 1'b1;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        HI,
        LO
    } rx_state_t;

    function automatic logic [ERR_W-1:0] make_err(input logic odd,
                                                  input logic runt,
                                                  input logic too_long);
        logic [ERR_W-1:0] e;
        e           = '0;
        e[ERR_ODD]  = odd;
        e[ERR_RUNT] = runt;
        e[ERR_LONG] = too_long;
        return e;
    endfunction

endpackage

// File: rtl/phy_rx_nibble_pack.sv
// Nibble latch and byte assembly for the receive deframer.
// Produces the registered byte stream with its start-of-frame marker.
module phy_rx_nibble_pack
    import xmit_pkg::*;
(
    input  logic       clk_phy,
    input  logic       reset,
    input  logic [3:0] phy_data_in,
    input  logic       lo_load,
    input  logic       byte_en,
    input  logic       first_byte,
    output logic [7:0] byte_asm,
    output logic [7:0] f_data_out,
    output logic       f_data_valid,
    output logic       f_sof
);

    logic [3:0] lo_nib;

    assign byte_asm = NIBBLE_LO_FIRST ? {phy_data_in, lo_nib} : {lo_nib, phy_data_in};

    always_ff @(posedge clk_phy) begin
        // NOTE: the nibble latch is cleared on reset too, so an aborted frame leaves no stale half-byte.
        if (reset) begin
            lo_nib       <= '0;
            f_data_out   <= '0;
            f_data_valid <= 1'b0;
            f_sof        <= 1'b0;
        end else begin
            f_data_valid <= byte_en;
            f_sof        <= byte_en & first_byte;
            if (lo_load) lo_nib <= phy_data_in;
            if (byte_en) f_data_out <= byte_asm;
        end
    end

endmodule

// File: rtl/phy_rx_frame.sv
// Receive-side PHY deframer: nibble stream in, byte stream plus per-frame
// length/error/priority status out.
module phy_rx_frame
    import xmit_pkg::*;
#(
    parameter int MIN_LEN   = 8,
    parameter int MAX_LEN   = 2048,
    parameter int PRIO_BYTE = 4,
    parameter int PRIO_BIT  = 4
) (
    input  logic              clk_phy,
    input  logic              reset,
    input  logic [3:0]        phy_data_in,
    input  logic              phy_rx_en,
    output logic [7:0]        f_data_out,
    output logic              f_data_valid,
    output logic              f_sof,
    output logic [CTRL_W-1:0] f_ctrl_out,
    output logic              f_ctrl_valid,
    output logic [ERR_W-1:0]  f_err,
    output logic              f_hi_priority
);

    localparam logic [CTRL_W-1:0] MIN_C    = CTRL_W'(MIN_LEN);
    localparam logic [CTRL_W-1:0] MAX_C    = CTRL_W'(MAX_LEN);
    localparam logic [CTRL_W-1:0] PRIO_C   = CTRL_W'(PRIO_BYTE);
    localparam logic [2:0]        PRIO_IDX = 3'(PRIO_BIT);

    rx_state_t         state;
    logic [CTRL_W-1:0] byte_cnt;
    logic              long_flag;
    logic              prio_flag;

    logic       lo_load;
    logic       byte_done;
    logic       byte_en;
    logic [7:0] byte_asm;

    assign lo_load   = phy_rx_en && (state == IDLE || state == LO);
    assign byte_done = phy_rx_en && (state == HI);
    // Bytes beyond the ceiling are assembled but never forwarded.
    assign byte_en   = byte_done && (byte_cnt < MAX_C);

    phy_rx_nibble_pack u_pack (
        .clk_phy      (clk_phy),
        .reset        (reset),
        .phy_data_in  (phy_data_in),
        .lo_load      (lo_load),
        .byte_en      (byte_en),
        .first_byte   (byte_cnt == '0),
        .byte_asm     (byte_asm),
        .f_data_out   (f_data_out),
        .f_data_valid (f_data_valid),
        .f_sof        (f_sof)
    );

    always_ff @(posedge clk_phy) begin
        if (reset) begin
            state         <= WAIT_IDLE;
            byte_cnt      <= '0;
            long_flag     <= 1'b0;
            prio_flag     <= 1'b0;
            f_ctrl_out    <= '0;
            f_ctrl_valid  <= 1'b0;
            f_err         <= '0;
            f_hi_priority <= 1'b0;
        end else begin
            f_ctrl_valid <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    if (!phy_rx_en) state <= IDLE;
                end
                IDLE: begin
                    if (phy_rx_en) begin
                        state     <= HI;
                        byte_cnt  <= '0;
                        long_flag <= 1'b0;
                        prio_flag <= 1'b0;
                    end
                end
                HI: begin
                    if (phy_rx_en) begin
                        state <= LO;
                        if (byte_cnt < MAX_C) begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == PRIO_C) prio_flag <= byte_asm[PRIO_IDX];
                        end else begin
                            long_flag <= 1'b1;
                        end
                    end else begin
                        // Trailing low nibble is simply dropped; count already excludes it.
                        state         <= IDLE;
                        f_ctrl_valid  <= 1'b1;
                        f_ctrl_out    <= byte_cnt;
                        f_err         <= make_err(1'b1, byte_cnt < MIN_C, long_flag);
                        f_hi_priority <= prio_flag;
                    end
                end
                LO: begin
                    if (phy_rx_en) begin
                        state <= HI;
                    end else begin
                        state         <= IDLE;
                        f_ctrl_valid  <= 1'b1;
                        f_ctrl_out    <= byte_cnt;
                        f_err         <= make_err(1'b0, byte_cnt < MIN_C, long_flag);
                        f_hi_priority <= prio_flag;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule
